audio_tdm_tx: RTL

- Parametrised multi-channel audio serializer: accepts one frame of N channel samples per frame through a valid/ready holding register and shifts them out MSB-first in fixed-width slots.
- Generates a frame-sync pulse and supports left-justified and I2S (one-bit-delay) modes.
- Sits between the sample source (DSP/tone generator) and the codec serial data pin; bit timing comes from a bit-clock enable strobe in the system clock domain.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_slot_counter.sv | 79 +++++++
 rtl/audio_tdm_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared encodings and parameter legality check for the TDM audio transmitter.
// Imported by the top level and the slot counter.
package audio_pkg;

  localparam logic MODE_LJ  = 1'b0;
  localparam logic MODE_I2S = 1'b1;

  function automatic bit params_ok(int sample_w, int slot_w, int channels, int frame_len);
    return (sample_w >= 1) && (sample_w <= 32) &&
           (slot_w >= sample_w) &&
           (channels >= 1) && (channels <= 8) &&
           (frame_len >= channels * slot_w + 1);
  endfunction

endpackage

// File: rtl/audio_slot_counter.sv
// Frame bit index plus slot / in-slot position tracking, advanced on bit_en.
// Exposes next-state position so the serializer can register sdata for the new index.
module audio_slot_counter
  import audio_pkg::*;
#(
  parameter int SLOT_W    = 16,
  parameter int CHANNELS  = 2,
  parameter int FRAME_LEN = 251,
  localparam int IDX_W    = $clog2(FRAME_LEN),
  localparam int SLOT_CW  = $clog2(CHANNELS + 1),
  localparam int POS_W    = (SLOT_W > 1) ? $clog2(SLOT_W) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               bit_en,
  input  logic               mode,
  output logic [IDX_W-1:0]   bit_idx,
  output logic [SLOT_CW-1:0] slot_next,
  output logic [POS_W-1:0]   pos_next,
  output logic               pos_valid_next,
  output logic               frame_start,
  output logic               last_bit
);

  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [SLOT_CW-1:0] slot_reg;
  logic [POS_W-1:0]   pos_reg;
  // Set for the leading blank bit of an I2S frame; position stays parked at slot 0 bit 0.
  logic               lead_reg, lead_next;

  assign last_bit    = (idx_reg == IDX_W'(FRAME_LEN - 1));
  assign frame_start = bit_en && last_bit;
  assign bit_idx     = idx_reg;

  always_comb begin
    idx_next  = idx_reg;
    slot_next = slot_reg;
    pos_next  = pos_reg;
    lead_next = lead_reg;
    if (bit_en) begin
      if (last_bit) begin
        idx_next  = '0;
        slot_next = '0;
        pos_next  = '0;
        lead_next = (mode == MODE_I2S);
      end else begin
        idx_next = idx_reg + 1'b1;
        if (lead_reg) begin
          lead_next = 1'b0;
        end else if (slot_reg != SLOT_CW'(CHANNELS)) begin
          if (pos_reg == POS_W'(SLOT_W - 1)) begin
            pos_next  = '0;
            slot_next = slot_reg + 1'b1;
          end else begin
            pos_next = pos_reg + 1'b1;
          end
        end
      end
    end
  end

  // Slot index CHANNELS marks the idle tail of the frame.
  assign pos_valid_next = !lead_next && (slot_next != SLOT_CW'(CHANNELS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_reg  <= IDX_W'(FRAME_LEN - 1);
      slot_reg <= SLOT_CW'(CHANNELS);
      pos_reg  <= '0;
      lead_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      slot_reg <= slot_next;
      pos_reg  <= pos_next;
      lead_reg <= lead_next;
    end
  end

endmodule

// File: rtl/audio_tdm_tx.sv
// Multi-channel TDM audio serializer: valid/ready holding register, frame buffer,
// MSB-first slot serialization with frame sync in left-justified or I2S timing.
module audio_tdm_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 16,
  parameter int CHANNELS  = 2,
  parameter int FRAME_LEN = 251
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         bit_en,
  input  logic                         mode,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         sdata,
  output logic                         fsync,
  output logic [$clog2(FRAME_LEN)-1:0] bit_idx,
  output logic                         underrun
);

  localparam int SLOT_CW   = $clog2(CHANNELS + 1);
  localparam int POS_W     = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SLOT_SPAN = 1 << POS_W;
  localparam int CH_SPAN   = 1 << SLOT_CW;

  if (!params_ok(SAMPLE_W, SLOT_W, CHANNELS, FRAME_LEN)) begin : g_bad_params
    $error("audio_tdm_tx: illegal SAMPLE_W/SLOT_W/CHANNELS/FRAME_LEN combination");
  end

  logic [CHANNELS*SAMPLE_W-1:0] hold_reg;
  logic [CHANNELS*SAMPLE_W-1:0] frame_reg, frame_next;
  logic                         hold_valid_reg;
  logic                         sdata_reg, fsync_reg, underrun_reg;
  logic [SLOT_CW-1:0]           slot_next;
  logic [POS_W-1:0]             pos_next;
  logic                         pos_valid_next;
  logic                         frame_start, last_bit;
  logic [CH_SPAN-1:0]           chan_bit;
  logic                         sdata_next;

  audio_slot_counter #(
    .SLOT_W    (SLOT_W),
    .CHANNELS  (CHANNELS),
    .FRAME_LEN (FRAME_LEN)
  ) u_slot_counter (
    .clk            (clk),
    .reset_n        (reset_n),
    .bit_en         (bit_en),
    .mode           (mode),
    .bit_idx        (bit_idx),
    .slot_next      (slot_next),
    .pos_next       (pos_next),
    .pos_valid_next (pos_valid_next),
    .frame_start    (frame_start),
    .last_bit       (last_bit)
  );

  assign s_ready  = !hold_valid_reg;
  assign sdata    = sdata_reg;
  assign fsync    = fsync_reg;
  assign underrun = underrun_reg;

  // Bit 0 of a frame must already see the freshly loaded (or zeroed) buffer.
  assign frame_next = frame_start ? (hold_valid_reg ? hold_reg : '0) : frame_reg;

  // Per channel: sample bits reordered MSB-first by in-slot position, zero padded.
  for (genvar gi = 0; gi < CH_SPAN; gi++) begin : g_chan
    if (gi < CHANNELS) begin : g_live
      logic [SLOT_SPAN-1:0] slot_bits;
      for (genvar gj = 0; gj < SLOT_SPAN; gj++) begin : g_bit
        if (gj < SAMPLE_W) begin : g_data
          assign slot_bits[gj] = frame_next[gi*SAMPLE_W + SAMPLE_W - 1 - gj];
        end else begin : g_pad
          assign slot_bits[gj] = 1'b0;
        end
      end
      assign chan_bit[gi] = slot_bits[pos_next];
    end else begin : g_idle
      assign chan_bit[gi] = 1'b0;
    end
  end

  assign sdata_next = pos_valid_next && chan_bit[slot_next];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_valid_reg <= 1'b0;
      frame_reg      <= '0;
      sdata_reg      <= 1'b0;
      fsync_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      underrun_reg <= bit_en && last_bit && !hold_valid_reg;
      frame_reg    <= frame_next;
      if (frame_start && hold_valid_reg) begin
        hold_valid_reg <= 1'b0;
      end else if (s_valid && !hold_valid_reg) begin
        hold_valid_reg <= 1'b1;
        hold_reg       <= s_data;
      end
      if (bit_en) begin
        sdata_reg <= sdata_next;
        fsync_reg <= frame_start;
      end
    end
  end

endmodule
